// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types, defaults and cause priority for the pipeline controller
package pipeline_ctrl_pkg;

    localparam int REG_W_DEF    = 5;
    localparam int WAIT_MAX_DEF = 1023;
    localparam int CNT_W_DEF    = 32;

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        HALTED
    } pctrl_state_t;

    typedef enum logic [2:0] {
        C_HALT,
        C_DMEM,
        C_REDIR,
        C_LOADUSE,
        C_IMISS,
        C_NONE
    } stall_cause_t;

    // Fixed priority: the first asserted cause wins.
    function automatic stall_cause_t pick_cause(
        input logic halt_req,
        input logic dstall,
        input logic redirect,
        input logic loaduse,
        input logic imiss
    );
        return halt_req ? C_HALT    :
               dstall   ? C_DMEM    :
               redirect ? C_REDIR   :
               loaduse  ? C_LOADUSE :
               imiss    ? C_IMISS   : C_NONE;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and pipe-register controls between datapath and controller
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             ihit;
    logic             dhit;
    logic             mem_req;
    logic             redirect;
    logic             ex_dREN;
    logic [REG_W-1:0] ex_wsel;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             wb_halt;

    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             ex_mem_flush;
    logic             mem_wb_en;
    logic             mem_wb_flush;
    logic             mem_squash;
    logic             halt;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    // Datapath side: supplies hazard status, consumes the controls.
    modport master (
        output ihit, dhit, mem_req, redirect, ex_dREN, ex_wsel, id_rs, id_rt, wb_halt,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush,
               mem_squash, halt, mem_timeout, stall_cycles
    );

    // Controller side.
    modport slave (
        input  ihit, dhit, mem_req, redirect, ex_dREN, ex_wsel, id_rs, id_rt, wb_halt,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush,
               mem_squash, halt, mem_timeout, stall_cycles
    );

endinterface

// File: rtl/pipeline_ctrl_load_use.sv
// load_use_detect: flags an ID-stage source that depends on a load still in EX
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             i_ex_dREN,
    input  logic [REG_W-1:0] i_ex_wsel,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_loaduse
);

    // $zero is never a real dependency, so a load targeting it cannot stall.
    assign o_loaduse = i_ex_dREN & (|i_ex_wsel) &
                       ((i_ex_wsel == i_id_rs) | (i_ex_wsel == i_id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencing, halt, dmem watchdog and stall counter for the 5-stage pipe
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input logic            CLK,
    input logic            nRST,
    pipeline_ctrl_if.slave bus
);

    localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_DWAIT  = DWAIT;
    localparam logic [1:0] ST_HALTED = HALTED;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WCW-1:0]   r_wcnt;
    logic [WCW-1:0]   w_wcnt_nxt;
    logic [CNT_W-1:0] r_stall;
    logic             r_timeout;

    logic             w_dstall;
    logic             w_loaduse;
    logic             w_imiss;
    logic             w_halt_req;
    logic             w_stall_inc;
    stall_cause_t     w_cause;

    logic             w_pc_en;
    logic             w_if_id_en;
    logic             w_if_id_flush;
    logic             w_id_ex_en;
    logic             w_id_ex_flush;
    logic             w_ex_mem_en;
    logic             w_mem_wb_flush;
    logic             w_mem_squash;

    load_use_detect #(.REG_W(REG_W)) u_load_use (
        .i_ex_dREN (bus.ex_dREN),
        .i_ex_wsel (bus.ex_wsel),
        .i_id_rs   (bus.id_rs),
        .i_id_rt   (bus.id_rt),
        .o_loaduse (w_loaduse)
    );

    assign w_dstall   = bus.mem_req & ~bus.dhit;
    assign w_imiss    = ~bus.ihit;
    assign w_halt_req = (r_state == ST_HALTED) | bus.wb_halt;
    assign w_cause    = pick_cause(w_halt_req, w_dstall, bus.redirect, w_loaduse, w_imiss);

    // Translate the winning cause into PC enable and pipe-register EN/flush pairs.
    always_comb begin
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_en     = 1'b1;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_en    = 1'b1;
        w_mem_wb_flush = 1'b0;
        w_mem_squash   = 1'b0;
        case (w_cause)
            C_HALT: begin
                w_pc_en      = 1'b0;
                w_if_id_en   = 1'b0;
                w_id_ex_en   = 1'b0;
                w_ex_mem_en  = 1'b0;
                w_mem_squash = 1'b1;
            end
            C_DMEM: begin
                w_pc_en        = 1'b0;
                w_if_id_en     = 1'b0;
                w_id_ex_en     = 1'b0;
                w_ex_mem_en    = 1'b0;
                w_mem_wb_flush = 1'b1;
            end
            C_REDIR: begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end
            C_LOADUSE: begin
                w_pc_en       = 1'b0;
                w_if_id_en    = 1'b0;
                w_id_ex_flush = 1'b1;
            end
            C_IMISS: begin
                w_pc_en       = 1'b0;
                w_if_id_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.if_id_en     = w_if_id_en;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_en     = w_id_ex_en;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.ex_mem_en    = w_ex_mem_en;
    assign bus.ex_mem_flush = 1'b0;
    assign bus.mem_wb_en    = ~w_mem_squash;
    assign bus.mem_wb_flush = w_mem_wb_flush;
    assign bus.mem_squash   = w_mem_squash;
    assign bus.halt         = (r_state == ST_HALTED);
    assign bus.mem_timeout  = r_timeout;
    assign bus.stall_cycles = r_stall;

    // Halt dominates, an outstanding data access parks in DWAIT, everything else runs.
    assign w_state_nxt = (w_cause == C_HALT) ? ST_HALTED :
                         (w_cause == C_DMEM) ? ST_DWAIT  : ST_RUN;

    // Wait counter only advances while parked in DWAIT and saturates at the watchdog limit.
    assign w_wcnt_nxt = (w_cause == C_DMEM && r_state == ST_DWAIT) ?
                        ((r_wcnt == WCW'(WAIT_MAX)) ? r_wcnt : r_wcnt + WCW'(1)) : '0;

    // Halt-related freezes are not counted as stalls.
    assign w_stall_inc = ~w_pc_en & (r_state != ST_HALTED) & ~bus.wb_halt;

    // State, watchdog and performance counter registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= ST_RUN;
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
            r_stall   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_timeout <= r_timeout | (w_wcnt_nxt == WCW'(WAIT_MAX));
            r_stall   <= (w_stall_inc && !(&r_stall)) ? r_stall + CNT_W'(1) : r_stall;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of stall priority, dmem wait, halt, watchdog and reset
module tb_pipeline_ctrl;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();
    pipeline_ctrl_if #(.REG_W(5), .CNT_W(32)) bus_wd ();

    pipeline_ctrl #(.REG_W(5), .WAIT_MAX(1023), .CNT_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    pipeline_ctrl #(.REG_W(5), .WAIT_MAX(4), .CNT_W(32)) dut_wd (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_wd)
    );

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mem_squash}
    logic [9:0] ctl;
    assign ctl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
                  bus.ex_mem_en, bus.ex_mem_flush, bus.mem_wb_en, bus.mem_wb_flush, bus.mem_squash};

    localparam logic [9:0] RUNV   = 10'b1_1_0_1_0_1_0_1_0_0;
    localparam logic [9:0] HALTV  = 10'b0_0_0_0_0_0_0_0_0_1;
    localparam logic [9:0] DMEMV  = 10'b0_0_0_0_0_0_0_1_1_0;
    localparam logic [9:0] REDIRV = 10'b1_1_1_1_1_1_0_1_0_0;
    localparam logic [9:0] LUV    = 10'b0_0_0_1_1_1_0_1_0_0;
    localparam logic [9:0] IMISSV = 10'b0_1_1_1_0_1_0_1_0_0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        bus.ihit = 1'b1; bus.dhit = 1'b0; bus.mem_req = 1'b0; bus.redirect = 1'b0;
        bus.ex_dREN = 1'b0; bus.ex_wsel = '0; bus.id_rs = '0; bus.id_rt = '0; bus.wb_halt = 1'b0;
        bus_wd.ihit = 1'b1; bus_wd.dhit = 1'b0; bus_wd.mem_req = 1'b0; bus_wd.redirect = 1'b0;
        bus_wd.ex_dREN = 1'b0; bus_wd.ex_wsel = '0; bus_wd.id_rs = '0; bus_wd.id_rt = '0; bus_wd.wb_halt = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ctl !== RUNV) begin n_errors++; $display("FAIL reset_ctl got %b exp %b", ctl, RUNV); end
        n_checks++; if (bus.halt !== 1'b0) begin n_errors++; $display("FAIL reset_halt got %b exp 0", bus.halt); end
        n_checks++; if (bus.mem_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout got %b exp 0", bus.mem_timeout); end
        n_checks++; if (bus.stall_cycles !== 32'd0) begin n_errors++; $display("FAIL reset_stall got %0d exp 0", bus.stall_cycles); end
    endtask

    task automatic test_loaduse();
        do_reset();
        bus.ex_dREN = 1'b1; bus.ex_wsel = 5'd8; bus.id_rs = 5'd8; bus.id_rt = 5'd1;
        #1;
        n_checks++; if (ctl !== LUV) begin n_errors++; $display("FAIL lu_rs_ctl got %b exp %b", ctl, LUV); end
        step();
        n_checks++; if (bus.stall_cycles !== 32'd1) begin n_errors++; $display("FAIL lu_rs_stall got %0d exp 1", bus.stall_cycles); end
        bus.id_rs = 5'd3; bus.id_rt = 5'd8;
        #1;
        n_checks++; if (ctl !== LUV) begin n_errors++; $display("FAIL lu_rt_ctl got %b exp %b", ctl, LUV); end
        step();
        n_checks++; if (bus.stall_cycles !== 32'd2) begin n_errors++; $display("FAIL lu_rt_stall got %0d exp 2", bus.stall_cycles); end
        bus.ex_wsel = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        #1;
        n_checks++; if (ctl !== RUNV) begin n_errors++; $display("FAIL lu_zero_ctl got %b exp %b", ctl, RUNV); end
        bus.ex_dREN = 1'b0; bus.ex_wsel = 5'd8; bus.id_rs = 5'd8;
        #1;
        n_checks++; if (ctl !== RUNV) begin n_errors++; $display("FAIL lu_noload_ctl got %b exp %b", ctl, RUNV); end
        step();
        n_checks++; if (bus.stall_cycles !== 32'd2) begin n_errors++; $display("FAIL lu_idle_stall got %0d exp 2", bus.stall_cycles); end
    endtask

    task automatic test_imiss();
        do_reset();
        bus.ihit = 1'b0;
        #1;
        n_checks++; if (ctl !== IMISSV) begin n_errors++; $display("FAIL imiss_ctl got %b exp %b", ctl, IMISSV); end
        step();
        n_checks++; if (bus.stall_cycles !== 32'd1) begin n_errors++; $display("FAIL imiss_stall got %0d exp 1", bus.stall_cycles); end
    endtask

    task automatic test_priority();
        do_reset();
        bus.ihit = 1'b0; bus.ex_dREN = 1'b1; bus.ex_wsel = 5'd8; bus.id_rs = 5'd8;
        #1;
        n_checks++; if (ctl !== LUV) begin n_errors++; $display("FAIL lu_over_imiss got %b exp %b", ctl, LUV); end
        step();
        bus.redirect = 1'b1;
        #1;
        n_checks++; if (ctl !== REDIRV) begin n_errors++; $display("FAIL redir_ctl got %b exp %b", ctl, REDIRV); end
        step();
        n_checks++; if (bus.stall_cycles !== 32'd1) begin n_errors++; $display("FAIL redir_stall got %0d exp 1", bus.stall_cycles); end
        bus.mem_req = 1'b1; bus.dhit = 1'b0;
        #1;
        n_checks++; if (ctl !== DMEMV) begin n_errors++; $display("FAIL dmem_over_redir got %b exp %b", ctl, DMEMV); end
        step();
        bus.dhit = 1'b1;
        #1;
        n_checks++; if (ctl !== REDIRV) begin n_errors++; $display("FAIL redir_after_dhit got %b exp %b", ctl, REDIRV); end
        step();
        n_checks++; if (bus.stall_cycles !== 32'd2) begin n_errors++; $display("FAIL prio_stall got %0d exp 2", bus.stall_cycles); end
    endtask

    task automatic test_dmem_wait();
        do_reset();
        bus.mem_req = 1'b1; bus.dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (ctl !== DMEMV) begin n_errors++; $display("FAIL dwait_ctl cycle %0d got %b exp %b", i, ctl, DMEMV); end
            step();
        end
        n_checks++; if (bus.stall_cycles !== 32'd3) begin n_errors++; $display("FAIL dwait_stall got %0d exp 3", bus.stall_cycles); end
        bus.dhit = 1'b1;
        #1;
        n_checks++; if (ctl !== RUNV) begin n_errors++; $display("FAIL dhit_ctl got %b exp %b", ctl, RUNV); end
        step();
        n_checks++; if (bus.stall_cycles !== 32'd3) begin n_errors++; $display("FAIL dhit_stall got %0d exp 3", bus.stall_cycles); end
        bus.mem_req = 1'b0; bus.dhit = 1'b1;
        #1;
        n_checks++; if (ctl !== RUNV) begin n_errors++; $display("FAIL stray_dhit_ctl got %b exp %b", ctl, RUNV); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.wb_halt = 1'b1; bus.mem_req = 1'b1; bus.dhit = 1'b0;
        #1;
        n_checks++; if (ctl !== HALTV) begin n_errors++; $display("FAIL halt_ctl got %b exp %b", ctl, HALTV); end
        n_checks++; if (bus.halt !== 1'b0) begin n_errors++; $display("FAIL halt_early got %b exp 0", bus.halt); end
        step();
        for (int i = 0; i < 10; i++) begin
            bus.ihit = 1'($urandom); bus.dhit = 1'($urandom); bus.mem_req = 1'($urandom);
            bus.redirect = 1'($urandom); bus.ex_dREN = 1'($urandom); bus.ex_wsel = 5'($urandom);
            bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom); bus.wb_halt = 1'($urandom);
            #1;
            n_checks++; if (bus.halt !== 1'b1) begin n_errors++; $display("FAIL halt_sticky cycle %0d got %b exp 1", i, bus.halt); end
            n_checks++; if (ctl !== HALTV) begin n_errors++; $display("FAIL halted_ctl cycle %0d got %b exp %b", i, ctl, HALTV); end
            step();
        end
        n_checks++; if (bus.stall_cycles !== 32'd0) begin n_errors++; $display("FAIL halt_stall got %0d exp 0", bus.stall_cycles); end
        do_reset();
        n_checks++; if (bus.halt !== 1'b0) begin n_errors++; $display("FAIL halt_reset got %b exp 0", bus.halt); end
        n_checks++; if (ctl !== RUNV) begin n_errors++; $display("FAIL halt_reset_ctl got %b exp %b", ctl, RUNV); end
    endtask

    task automatic test_watchdog();
        do_reset();
        bus_wd.mem_req = 1'b1; bus_wd.dhit = 1'b0;
        step();
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (bus_wd.mem_timeout !== 1'b0) begin n_errors++; $display("FAIL wd_early got %b exp 0", bus_wd.mem_timeout); end
        step();
        n_checks++; if (bus_wd.mem_timeout !== 1'b1) begin n_errors++; $display("FAIL wd_fire got %b exp 1", bus_wd.mem_timeout); end
        step();
        step();
        n_checks++; if (bus_wd.stall_cycles !== 32'd7) begin n_errors++; $display("FAIL wd_stall got %0d exp 7", bus_wd.stall_cycles); end
        bus_wd.dhit = 1'b1;
        step();
        bus_wd.mem_req = 1'b0;
        step();
        n_checks++; if (bus_wd.mem_timeout !== 1'b1) begin n_errors++; $display("FAIL wd_sticky got %b exp 1", bus_wd.mem_timeout); end
        n_checks++; if (bus_wd.stall_cycles !== 32'd7) begin n_errors++; $display("FAIL wd_stall_after got %0d exp 7", bus_wd.stall_cycles); end
        do_reset();
        n_checks++; if (bus_wd.mem_timeout !== 1'b0) begin n_errors++; $display("FAIL wd_reset got %b exp 0", bus_wd.mem_timeout); end
    endtask

    task automatic test_reset_mid_dwait();
        do_reset();
        bus.mem_req = 1'b1; bus.dhit = 1'b0;
        bus_wd.mem_req = 1'b1; bus_wd.dhit = 1'b0;
        step();
        step();
        step();
        step();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        #1;
        n_checks++; if (bus.stall_cycles !== 32'd0) begin n_errors++; $display("FAIL mid_stall got %0d exp 0", bus.stall_cycles); end
        n_checks++; if (bus.halt !== 1'b0) begin n_errors++; $display("FAIL mid_halt got %b exp 0", bus.halt); end
        step();
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (bus_wd.mem_timeout !== 1'b0) begin n_errors++; $display("FAIL mid_residue got %b exp 0", bus_wd.mem_timeout); end
        n_checks++; if (bus_wd.stall_cycles !== 32'd4) begin n_errors++; $display("FAIL mid_wd_stall got %0d exp 4", bus_wd.stall_cycles); end
        set_idle();
        #1;
        n_checks++; if (ctl !== RUNV) begin n_errors++; $display("FAIL mid_ctl got %b exp %b", ctl, RUNV); end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_loaduse();
        test_imiss();
        test_priority();
        test_dmem_wait();
        test_halt();
        test_watchdog();
        test_reset_mid_dwait();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
